// File: rtl/uart_pkg.sv
// uart_pkg: state encodings shared by the UART transmitter and receiver,
// default line settings and the clocks-per-bit derivation.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;

  function automatic int clk_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_baud_cnt.sv
// uart_tx_baud_cnt: per-bit cycle counter; bit_end pulses on the last cycle
// of each bit period and the count restarts from zero on the following cycle.
module uart_tx_baud_cnt #(
  parameter int CLK_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);
  logic [15:0] r_count;

  assign bit_end = en && !clr && (r_count == 16'(CLK_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (clr) r_count <= '0;
    else if (en) r_count <= bit_end ? 16'd0 : r_count + 16'd1;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with valid/ready byte input.
// Define UART_TX_PARITY_EN to send an even-parity bit (8E1 frame).
module uart_tx import uart_pkg::*; #(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int BAUD        = DEF_BAUD,
  parameter int CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] debug_state,
  output logic [3:0] debug_bit_cnt
);
  uart_state_e r_state;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic [3:0]  r_bit_idx;
  logic        r_out;
  logic        r_done;
  logic        w_idle;
  logic        w_bit_end;

  assign w_idle        = (r_state == IDLE);
  assign tx_ready      = w_idle;
  assign tx_busy       = !w_idle;
  assign uart_tx_out   = r_out;
  assign tx_done       = r_done;
  assign debug_state   = r_state;
  assign debug_bit_cnt = r_bit_idx;

  uart_tx_baud_cnt #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_idle),
    .en      (!w_idle),
    .bit_end (w_bit_end)
  );

  // The shift register moves right once per data bit so bit 1 is always next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
      r_out     <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (tx_valid) begin
          r_shift   <= tx_data;
          r_parity  <= ^tx_data;
          r_bit_idx <= '0;
          r_out     <= 1'b0;
          r_state   <= START;
        end
        START: if (w_bit_end) begin
          r_out   <= r_shift[0];
          r_state <= DATA;
        end
        DATA: if (w_bit_end) begin
          if (r_bit_idx == 4'd7) begin
`ifdef UART_TX_PARITY_EN
            r_out   <= r_parity;
            r_state <= PARITY;
`else
            r_out   <= 1'b1;
            r_state <= STOP;
`endif
          end else begin
            r_bit_idx <= r_bit_idx + 4'd1;
            r_shift   <= r_shift >> 1;
            r_out     <= r_shift[1];
          end
        end
        PARITY: if (w_bit_end) begin
          r_out   <= 1'b1;
          r_state <= STOP;
        end
        STOP: if (w_bit_end) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: begin
          r_out   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a frame-level
// model; honours UART_TX_PARITY_EN for the 8E1 frame.
module tb_uart_tx;
  localparam int CPB = 7;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'hFF;
  logic       tx_valid = 1'b1;
  logic       tx_ready, uart_tx_out, tx_busy, tx_done;
  logic [2:0] debug_state;
  logic [3:0] debug_bit_cnt;
  int         n_cmp = 0;
  int         n_err = 0;

  uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .uart_tx_out   (uart_tx_out),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .debug_state   (debug_state),
    .debug_bit_cnt (debug_bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level of frame bit i: start, d[0..7] LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (NB == 11 && i == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic logic [2:0] exp_state(input int i);
    if (i == 0) return 3'd1;
    if (i <= 8) return 3'd2;
    if (NB == 11 && i == 9) return 3'd3;
    return 3'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    check("ready_pre", tx_ready, 1);
    tick();
  endtask

  // Entered one step after the accepting edge; returns one step after the done edge.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] nxt, input bit hold);
    int b;
    for (int j = 0; j < NB * CPB; j++) begin
      b = j / CPB;
      check("line", uart_tx_out, exp_bit(d, b));
      check("ready_busy", {tx_ready, tx_busy}, 2'b01);
      check("done_low", tx_done, 0);
      check("state", debug_state, exp_state(b));
      if (b >= 1 && b <= 8) check("bit_cnt", debug_bit_cnt, b - 1);
      if (j == 0) begin
        tx_data  = nxt;
        tx_valid = hold;
      end
      tick();
    end
    check("done", tx_done, 1);
    check("ready_end", tx_ready, 1);
    check("line_stop", uart_tx_out, 1);
  endtask

  task automatic idle(input int n);
    tx_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_line", uart_tx_out, 1);
      check("idle_done", tx_done, 0);
      check("idle_state", debug_state, 0);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] fixed [4];
    fixed[0] = 8'h55; fixed[1] = 8'h07; fixed[2] = 8'h03; fixed[3] = 8'h00;
    repeat (3) tick();
    check("rst_line", uart_tx_out, 1);
    check("rst_done", tx_done, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_state", debug_state, 0);
    check("rst_bit_cnt", debug_bit_cnt, 0);
    tx_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    for (int k = 0; k < 4; k++) begin
      start(fixed[k]);
      run_frame(fixed[k], 8'hFF, 0);
      idle(2);
    end

    start(8'hA5);
    run_frame(8'hA5, 8'h3C, 1);
    tick();
    run_frame(8'h3C, 8'(
      $urandom), 0);
    idle(3);

    start(8'h5A);
    tx_valid = 1'b0;
    repeat (4 * CPB + CPB / 2) tick();
    check("mid_state", debug_state, 2);
    rst_n = 1'b0;
    #1;
    check("arst_line", uart_tx_out, 1);
    check("arst_ready", tx_ready, 1);
    check("arst_busy", tx_busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_done", tx_done, 0);
      check("arst_hold", uart_tx_out, 1);
    end
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    start(8'h81);
    run_frame(8'h81, 8'h00, 0);
    idle(1);

    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom);
      start(d);
      run_frame(d, 8'($urandom), 0);
      idle($urandom_range(0, 3));
    end

    start(8'h00);
    for (int v = 0; v < 256; v++) begin
      run_frame(8'(v), 8'(v + 1), v != 255);
      if (v != 255) tick();
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
